fpu_ss_scoreboard_ctrl: RTL and testbench

Parametrised issue/dependency controller for the FPU subsystem, the successor of the single-bit-scoreboard controller. It sits between the input buffer head and the execution units (FPnew, LSU, Vicuna arbiter). It tracks per-register outstanding-write counts, so WAW to the same rd may be in flight more than once, and handles `NUM_WB` writeback ports with per-operand forwarding select. It gates dispatch on the commit/kill status of each X-interface ID, and drops killed instructions.

---
 rtl/fpu_ss_pkg.sv | 17 +
 rtl/fpu_ss_scoreboard_ctrl_if.sv | 48 ++++
 rtl/fpu_ss_sat_counter.sv | 35 +++
 rtl/fpu_ss_scoreboard_ctrl.sv | 140 ++++++++++++++
 tb/tb_fpu_ss_scoreboard_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_ss_pkg.sv
// Shared FPU-subsystem types: writeback port bundle and scoreboard counter type.
package fpu_ss_pkg;

  localparam int SB_CNT_W  = 2;
  // Widest register address carried in a writeback bundle (up to 32 FP registers).
  localparam int SB_AW_MAX = 5;

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;
  localparam sb_cnt_t SB_CNT_MAX = '1;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [SB_AW_MAX-1:0] addr;
  } wb_port_t;

endpackage

// File: rtl/fpu_ss_scoreboard_ctrl_if.sv
// Head / dispatch / commit / writeback bundle between the FPU issue logic and the scoreboard.
interface fpu_ss_scoreboard_ctrl_if #(
  parameter int NUM_REGS   = 32,
  parameter int NUM_OPS    = 3,
  parameter int NUM_WB     = 2,
  parameter int X_ID_WIDTH = 4
);
  localparam int AW = $clog2(NUM_REGS);

  logic                              head_valid_i;
  logic [X_ID_WIDTH-1:0]             head_id_i;
  logic [NUM_OPS-1:0][AW-1:0]        head_rs_i;
  logic [NUM_OPS-1:0]                head_rs_used_i;
  logic [AW-1:0]                     head_rd_i;
  logic                              head_rd_fp_i;
  logic                              head_pop_o;
  logic                              disp_valid_o;
  logic                              disp_ready_i;
  logic                              drop_o;
  logic                              commit_valid_i;
  logic [X_ID_WIDTH-1:0]             commit_id_i;
  logic                              commit_kill_i;
  logic [NUM_WB-1:0]                 wb_valid_i;
  logic [NUM_WB-1:0]                 wb_we_i;
  logic [NUM_WB-1:0][AW-1:0]         wb_addr_i;
  logic [NUM_OPS-1:0][NUM_WB-1:0]    fwd_sel_o;
  logic                              stall_raw_o;
  logic                              stall_cnt_o;
  logic [NUM_REGS-1:0]               pending_o;
  logic                              busy_o;

  modport master (
    output head_valid_i, head_id_i, head_rs_i, head_rs_used_i, head_rd_i, head_rd_fp_i,
           disp_ready_i, commit_valid_i, commit_id_i, commit_kill_i,
           wb_valid_i, wb_we_i, wb_addr_i,
    input  head_pop_o, disp_valid_o, drop_o, fwd_sel_o, stall_raw_o, stall_cnt_o,
           pending_o, busy_o
  );

  modport slave (
    input  head_valid_i, head_id_i, head_rs_i, head_rs_used_i, head_rd_i, head_rd_fp_i,
           disp_ready_i, commit_valid_i, commit_id_i, commit_kill_i,
           wb_valid_i, wb_we_i, wb_addr_i,
    output head_pop_o, disp_valid_o, drop_o, fwd_sel_o, stall_raw_o, stall_cnt_o,
           pending_o, busy_o
  );

endinterface

// File: rtl/fpu_ss_sat_counter.sv
// Per-register outstanding-write counter: +0/1 per cycle, -0..NUM_WB per cycle, floors at 0.
module fpu_ss_sat_counter #(
  parameter int CNT_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_inc,
  input  logic [DEC_W-1:0] i_dec,
  output logic [CNT_W-1:0] o_cnt
);

  localparam int            SW  = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;
  localparam logic [SW-1:0] MAX = SW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [SW-1:0]    w_up;
  logic [SW-1:0]    w_nxt;

  // Writebacks beyond the outstanding count (stale after a reset) just floor at zero.
  always_comb begin
    w_up = SW'(r_cnt) + SW'(i_inc);
    if (SW'(i_dec) >= w_up)          w_nxt = '0;
    else if (w_up - SW'(i_dec) > MAX) w_nxt = MAX;
    else                              w_nxt = w_up - SW'(i_dec);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_cnt <= '0;
    else         r_cnt <= w_nxt[CNT_W-1:0];
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fpu_ss_scoreboard_ctrl.sv
// FPU issue/dependency controller: per-register pending-write counts, multi-port
// forwarding select, and commit/kill gating of the input-buffer head.
module fpu_ss_scoreboard_ctrl
  import fpu_ss_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int NUM_OPS    = 3,
  parameter int NUM_WB     = 2,
  parameter int CNT_W      = SB_CNT_W,
  parameter int X_ID_WIDTH = 4,
  parameter bit FORWARDING = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  fpu_ss_scoreboard_ctrl_if.slave  bus
);

  localparam int               AW   = $clog2(NUM_REGS);
  localparam int               DW   = $clog2(NUM_WB + 1);
  localparam int               NID  = 2 ** X_ID_WIDTH;
  localparam logic [CNT_W-1:0] CMAX = '1;

  wb_port_t                       w_wb   [NUM_WB];
  logic [DW-1:0]                  w_dec  [NUM_REGS];
  logic [CNT_W-1:0]               w_cnt  [NUM_REGS];
  logic [NUM_REGS-1:0]            w_inc;
  logic [NUM_REGS-1:0]            w_pend;
  logic [NUM_OPS-1:0][NUM_WB-1:0] w_match;
  logic [NUM_OPS-1:0][NUM_WB-1:0] w_fwd;
  logic [NUM_OPS-1:0]             w_raw;
  logic [NID-1:0]                 r_cmt;
  logic [NID-1:0]                 r_kill;
  logic                           r_armed;
  logic                           w_ok_id;
  logic                           w_killed;
  logic                           w_scnt;
  logic                           w_disp;
  logic                           w_drop;
  logic                           w_hs;
  logic                           w_uflow;

  always_comb begin
    for (int p = 0; p < NUM_WB; p++) begin
      w_wb[p].valid = bus.wb_valid_i[p];
      w_wb[p].we    = bus.wb_we_i[p];
      w_wb[p].addr  = SB_AW_MAX'(bus.wb_addr_i[p]);
    end
  end

  // Number of writeback ports retiring each register this cycle.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_dec[r] = '0;
      for (int p = 0; p < NUM_WB; p++)
        if (w_wb[p].valid && w_wb[p].we && (w_wb[p].addr == SB_AW_MAX'(r)))
          w_dec[r] = w_dec[r] + 1'b1;
    end
  end

  // Forward only from the writeback that retires the last outstanding write; lowest port wins.
  always_comb begin
    w_match = '0;
    w_fwd   = '0;
    w_raw   = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      for (int p = 0; p < NUM_WB; p++)
        w_match[k][p] = w_wb[p].valid & w_wb[p].we &
                        (w_wb[p].addr == SB_AW_MAX'(bus.head_rs_i[k]));
      if (FORWARDING && (int'(w_cnt[bus.head_rs_i[k]]) == int'(w_dec[bus.head_rs_i[k]])))
        w_fwd[k] = w_match[k] & (~w_match[k] + 1'b1);
      w_raw[k] = bus.head_rs_used_i[k] & (w_cnt[bus.head_rs_i[k]] != '0) & ~(|w_fwd[k]);
    end
    if (!bus.head_valid_i) begin
      w_fwd = '0;
      w_raw = '0;
    end
  end

  assign w_ok_id  = r_cmt[bus.head_id_i] |
                    (bus.commit_valid_i & ~bus.commit_kill_i & (bus.commit_id_i == bus.head_id_i));
  assign w_killed = r_kill[bus.head_id_i] |
                    (bus.commit_valid_i & bus.commit_kill_i & (bus.commit_id_i == bus.head_id_i));
  assign w_scnt   = bus.head_valid_i & bus.head_rd_fp_i &
                    (w_cnt[bus.head_rd_i] == CMAX) & (w_dec[bus.head_rd_i] == '0);
  assign w_disp   = bus.head_valid_i & w_ok_id & ~w_killed & ~(|w_raw) & ~w_scnt;
  assign w_drop   = bus.head_valid_i & w_killed;
  assign w_hs     = w_disp & bus.disp_ready_i;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    assign w_inc[r]  = w_hs & bus.head_rd_fp_i & (bus.head_rd_i == AW'(r));
    assign w_pend[r] = |w_cnt[r];

    fpu_ss_sat_counter #(
      .CNT_W (CNT_W),
      .DEC_W (DW)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_inc  (w_inc[r]),
      .i_dec  (w_dec[r]),
      .o_cnt  (w_cnt[r])
    );
  end

  // A clear from the consuming dispatch/drop wins over a same-cycle set of the same ID.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cmt   <= '0;
      r_kill  <= '0;
      r_armed <= 1'b0;
    end else begin
      if (bus.commit_valid_i && !bus.commit_kill_i) r_cmt[bus.commit_id_i]  <= 1'b1;
      if (bus.commit_valid_i &&  bus.commit_kill_i) r_kill[bus.commit_id_i] <= 1'b1;
      if (w_hs)   r_cmt[bus.head_id_i]  <= 1'b0;
      if (w_drop) r_kill[bus.head_id_i] <= 1'b0;
      if (w_hs)   r_armed <= 1'b1;
    end
  end

  // Writebacks still in flight across a reset are expected to underflow; only flag
  // underflow once this reset epoch has dispatched something.
  always_comb begin
    w_uflow = 1'b0;
    for (int r = 0; r < NUM_REGS; r++)
      if (int'(w_dec[r]) > int'(w_cnt[r])) w_uflow = 1'b1;
    w_uflow = w_uflow & r_armed;
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) !w_uflow);

  assign bus.disp_valid_o = w_disp;
  assign bus.drop_o       = w_drop;
  assign bus.head_pop_o   = w_hs | w_drop;
  assign bus.fwd_sel_o    = w_fwd;
  assign bus.stall_raw_o  = |w_raw;
  assign bus.stall_cnt_o  = w_scnt;
  assign bus.pending_o    = w_pend;
  assign bus.busy_o       = (|w_pend) | (|r_cmt);

endmodule

// File: tb/tb_fpu_ss_scoreboard_ctrl.sv
// Directed bench for fpu_ss_scoreboard_ctrl: abstract count/ID model checked every cycle
// plus hand-computed literal expectations.
module tb_fpu_ss_scoreboard_ctrl;

  localparam int NR   = 32;
  localparam int NO   = 3;
  localparam int NW   = 2;
  localparam int CW   = 2;
  localparam int IW   = 4;
  localparam bit FWD  = 1'b1;
  localparam int CMAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_ss_scoreboard_ctrl_if #(.NUM_REGS(NR), .NUM_OPS(NO), .NUM_WB(NW), .X_ID_WIDTH(IW)) bus ();

  fpu_ss_scoreboard_ctrl #(
    .NUM_REGS(NR), .NUM_OPS(NO), .NUM_WB(NW), .CNT_W(CW), .X_ID_WIDTH(IW), .FORWARDING(FWD)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic disp, drop, pop, raw, scnt;
    logic [NO*NW-1:0] fwd;
  } exp_t;

  typedef struct {
    string       name;
    int          sig;
    int          idx;
    logic [63:0] val;
  } lit_t;

  lit_t lq[$];
  int   mcnt  [NR];
  bit   mcmt  [1<<IW];
  bit   mkill [1<<IW];
  int   n_pass = 0;
  int   n_chk  = 0;

  function automatic int wb_count(int r);
    int c = 0;
    for (int p = 0; p < NW; p++)
      if (bus.wb_valid_i[p] && bus.wb_we_i[p] && int'(bus.wb_addr_i[p]) == r) c++;
    return c;
  endfunction

  // Expected combinational outputs from the model state and the current inputs.
  function automatic exp_t model_eval();
    exp_t e = '0;
    int id, rs, src, rd;
    bit ok, kl;
    if (!bus.head_valid_i) return e;
    id = int'(bus.head_id_i);
    ok = mcmt[id]  || (bus.commit_valid_i && !bus.commit_kill_i && int'(bus.commit_id_i) == id);
    kl = mkill[id] || (bus.commit_valid_i &&  bus.commit_kill_i && int'(bus.commit_id_i) == id);
    for (int k = 0; k < NO; k++) begin
      rs  = int'(bus.head_rs_i[k]);
      src = -1;
      for (int p = NW - 1; p >= 0; p--)
        if (bus.wb_valid_i[p] && bus.wb_we_i[p] && int'(bus.wb_addr_i[p]) == rs) src = p;
      if (FWD && src >= 0 && mcnt[rs] == wb_count(rs)) e.fwd[k*NW+src] = 1'b1;
      else if (bus.head_rs_used_i[k] && mcnt[rs] != 0) e.raw = 1'b1;
    end
    rd     = int'(bus.head_rd_i);
    e.scnt = bus.head_rd_fp_i && mcnt[rd] == CMAX && wb_count(rd) == 0;
    e.disp = ok && !kl && !e.raw && !e.scnt;
    e.drop = kl;
    e.pop  = (e.disp && bus.disp_ready_i) || e.drop;
    return e;
  endfunction

  exp_t m_e;
  int   m_n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (mcnt[r]) mcnt[r] = 0;
      foreach (mcmt[i]) begin mcmt[i] = 1'b0; mkill[i] = 1'b0; end
    end else begin
      m_e = model_eval();
      for (int r = 0; r < NR; r++) begin
        m_n = mcnt[r] - wb_count(r);
        if (m_e.disp && bus.disp_ready_i && bus.head_rd_fp_i && int'(bus.head_rd_i) == r) m_n++;
        mcnt[r] = (m_n < 0) ? 0 : m_n;
      end
      if (bus.commit_valid_i) begin
        if (bus.commit_kill_i) mkill[int'(bus.commit_id_i)] = 1'b1;
        else                   mcmt[int'(bus.commit_id_i)]  = 1'b1;
      end
      if (m_e.disp && bus.disp_ready_i) mcmt[int'(bus.head_id_i)]  = 1'b0;
      if (m_e.drop)                     mkill[int'(bus.head_id_i)] = 1'b0;
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
  endtask

  exp_t        c_e;
  logic [NR-1:0] c_pend;
  logic        c_busy;
  lit_t        c_l;
  logic [63:0] c_act;
  always @(negedge clk) begin
    if (rst_n) begin
      c_e    = model_eval();
      c_pend = '0;
      c_busy = 1'b0;
      for (int r = 0; r < NR; r++) if (mcnt[r] != 0) begin c_pend[r] = 1'b1; c_busy = 1'b1; end
      for (int i = 0; i < (1 << IW); i++) if (mcmt[i]) c_busy = 1'b1;
      chk("disp_valid", 64'(bus.disp_valid_o), 64'(c_e.disp));
      chk("drop",       64'(bus.drop_o),       64'(c_e.drop));
      chk("head_pop",   64'(bus.head_pop_o),   64'(c_e.pop));
      chk("fwd_sel",    64'(bus.fwd_sel_o),    64'(c_e.fwd));
      chk("stall_raw",  64'(bus.stall_raw_o),  64'(c_e.raw));
      chk("stall_cnt",  64'(bus.stall_cnt_o),  64'(c_e.scnt));
      chk("pending",    64'(bus.pending_o),    64'(c_pend));
      chk("busy",       64'(bus.busy_o),       64'(c_busy));
      while (lq.size() > 0) begin
        c_l = lq.pop_front();
        case (c_l.sig)
          0:       c_act = 64'(bus.disp_valid_o);
          1:       c_act = 64'(bus.drop_o);
          2:       c_act = 64'(bus.head_pop_o);
          3:       c_act = 64'(bus.fwd_sel_o);
          4:       c_act = 64'(bus.stall_raw_o);
          5:       c_act = 64'(bus.stall_cnt_o);
          6:       c_act = 64'(bus.pending_o);
          7:       c_act = 64'(bus.busy_o);
          8:       c_act = 64'(bus.pending_o[c_l.idx]);
          default: c_act = 'x;
        endcase
        chk(c_l.name, c_act, c_l.val);
      end
    end
  end

  task automatic lit(string n, int s, logic [63:0] v, int idx = 0);
    lit_t t;
    t.name = n; t.sig = s; t.val = v; t.idx = idx;
    lq.push_back(t);
  endtask

  task automatic idle();
    bus.head_valid_i   = 1'b0;
    bus.head_id_i      = '0;
    bus.head_rs_i      = '0;
    bus.head_rs_used_i = '0;
    bus.head_rd_i      = '0;
    bus.head_rd_fp_i   = 1'b0;
    bus.disp_ready_i   = 1'b0;
    bus.commit_valid_i = 1'b0;
    bus.commit_id_i    = '0;
    bus.commit_kill_i  = 1'b0;
    bus.wb_valid_i     = '0;
    bus.wb_we_i        = '0;
    bus.wb_addr_i      = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic head(int id, int rd, bit fp);
    bus.head_valid_i = 1'b1;
    bus.head_id_i    = IW'(id);
    bus.head_rd_i    = 5'(rd);
    bus.head_rd_fp_i = fp;
  endtask

  task automatic src(int k, int a);
    bus.head_rs_i[k]      = 5'(a);
    bus.head_rs_used_i[k] = 1'b1;
  endtask

  task automatic cmt(int id, bit kill);
    bus.commit_valid_i = 1'b1;
    bus.commit_id_i    = IW'(id);
    bus.commit_kill_i  = kill;
  endtask

  task automatic wb(int p, int a);
    bus.wb_valid_i[p] = 1'b1;
    bus.wb_we_i[p]    = 1'b1;
    bus.wb_addr_i[p]  = 5'(a);
  endtask

  // Commit and dispatch in the same cycle, writing rd.
  task automatic go(int id, int rd);
    head(id, rd, 1'b1);
    cmt(id, 1'b0);
    bus.disp_ready_i = 1'b1;
    cyc();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    lit("rst_pending", 6, 0); lit("rst_busy", 7, 0);
    cyc();

    // same-cycle commit bypass
    head(3, 5, 1'b1); cmt(3, 1'b0); bus.disp_ready_i = 1'b1;
    lit("t1_disp", 0, 1); lit("t1_pop", 2, 1);
    cyc();
    head(3, 0, 1'b0);
    lit("t1_pend5", 8, 1, 5); lit("t1_cmt3_cleared", 0, 0);
    cyc();

    // WAW to f5 twice, then forward only on the last writeback
    wb(0, 5); cyc();
    go(4, 5); go(5, 5);
    head(6, 0, 1'b0); src(0, 5); cmt(6, 1'b0); bus.disp_ready_i = 1'b1; wb(0, 5);
    lit("t2_fwd_none", 3, 0); lit("t2_raw", 4, 1); lit("t2_nodisp", 0, 0);
    cyc();
    head(6, 0, 1'b0); src(0, 5); bus.disp_ready_i = 1'b1; wb(0, 5);
    lit("t2_fwd_p0", 3, 64'h1); lit("t2_raw_clr", 4, 0); lit("t2_disp", 0, 1);
    cyc();
    lit("t2_pend5_clr", 8, 0, 5);
    cyc();

    // counter saturation on f7
    go(7, 7); go(8, 7); go(10, 7);
    head(11, 7, 1'b1); cmt(11, 1'b0); bus.disp_ready_i = 1'b1;
    lit("t3_scnt", 5, 1); lit("t3_nodisp", 0, 0);
    cyc();
    head(11, 7, 1'b1); bus.disp_ready_i = 1'b1; wb(1, 7);
    lit("t3_scnt_wb", 5, 0); lit("t3_disp", 0, 1);
    cyc();
    head(12, 7, 1'b1);
    lit("t3_cnt_held", 5, 1);
    cyc();

    // both ports retire f2 together
    go(1, 2); go(2, 2);
    head(13, 0, 1'b0); src(1, 2); cmt(13, 1'b0); bus.disp_ready_i = 1'b1; wb(0, 2); wb(1, 2);
    lit("t4_fwd_op1_p0", 3, 64'h4); lit("t4_disp", 0, 1);
    cyc();
    lit("t4_pend2_clr", 8, 0, 2);
    cyc();

    // kills: same-cycle and from the kill table
    head(9, 0, 1'b0); cmt(9, 1'b1); bus.disp_ready_i = 1'b1;
    lit("t5_drop", 1, 1); lit("t5_pop", 2, 1); lit("t5_nodisp", 0, 0);
    cyc();
    lit("t5_pending", 6, 64'h80);
    cyc();
    cmt(14, 1'b1); cyc();
    head(14, 3, 1'b1); bus.disp_ready_i = 1'b1;
    lit("t5_drop_q", 1, 1); lit("t5_nodisp_q", 0, 0);
    cyc();
    lit("t5_pend3_none", 8, 0, 3);
    cyc();

    // reset mid-stream, then a stale writeback
    go(0, 4); go(15, 4);
    lit("t6_pend4", 8, 1, 4);
    cyc();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wb(0, 4);
    cyc();
    lit("t6_pending", 6, 0); lit("t6_busy", 7, 0);
    cyc();
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
